// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates a single-port RAM between an instruction-fetch
// requester and a data requester. Three-state FSM (IDLE / IACC / DACC) with an
// access watchdog that aborts an access after TIMEOUT cycles without ramready
// and raises a one-cycle err pulse.
//
// Optional feature macro: FAIR_ARB_EN
//   defined   -> alternating grant when both requesters are pending in IDLE
//                (a last-grant flop remembers who was served last; after
//                reset the instruction side counts as last granted, so data
//                wins the first tie)
//   undefined -> fixed priority, data always wins a tie; no last-grant flop

module memory_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction-fetch requester
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // data requester
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  // watchdog abort pulse
  output logic        err
);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IACC = 2'd1;
  localparam logic [1:0] ST_DACC = 2'd2;

  // Counter value on the last access cycle the watchdog tolerates
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [7:0] count_r;
  logic [7:0] count_next_s;
  logic       err_r;
  logic       err_next_s;
  logic       i_done_s;
  logic       d_done_s;
  logic       d_pending_s;
  logic       grant_data_s;

  assign d_pending_s = dREN | dWEN;

`ifdef FAIR_ARB_EN
  logic last_data_r;
  logic last_data_next_s;

  // Tie-break: serve whichever requester did not get the previous access
  always_comb begin
    if (d_pending_s && iREN) begin
      grant_data_s = ~last_data_r;
    end else begin
      grant_data_s = d_pending_s;
    end
  end

  // Record the requester of every access that is entered from IDLE
  always_comb begin
    last_data_next_s = last_data_r;
    if (state_r == ST_IDLE) begin
      if (grant_data_s) begin
        last_data_next_s = 1'b1;
      end else if (iREN) begin
        last_data_next_s = 1'b0;
      end else begin
        last_data_next_s = last_data_r;
      end
    end else begin
      last_data_next_s = last_data_r;
    end
  end

  // Last-grant flop; reset value means "instruction was last", so data wins first
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_data_r <= 1'b0;
    end else begin
      last_data_r <= last_data_next_s;
    end
  end
`else
  // Fixed priority: any pending data request beats the instruction fetch
  always_comb begin
    grant_data_s = d_pending_s;
  end
`endif

  // Next-state, watchdog counter and completion decode
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    err_next_s   = 1'b0;
    i_done_s     = 1'b0;
    d_done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // counter starts from zero on entry to any access
        count_next_s = 8'd0;
        if (grant_data_s) begin
          state_next_s = ST_DACC;
        end else if (iREN) begin
          state_next_s = ST_IACC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_IACC: begin
        if (!iREN) begin
          // requester withdrew: silent abort
          state_next_s = ST_IDLE;
        end else if (ramready) begin
          // ramready wins even on the watchdog's last cycle
          i_done_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else if (count_r == TIMEOUT_LAST) begin
          err_next_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          count_next_s = count_r + 8'd1;
        end
      end
      ST_DACC: begin
        if (!d_pending_s) begin
          state_next_s = ST_IDLE;
        end else if (ramready) begin
          d_done_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else if (count_r == TIMEOUT_LAST) begin
          err_next_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          count_next_s = count_r + 8'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        count_next_s = 8'd0;
      end
    endcase
  end

  // State, counter and err pulse registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      count_r <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      err_r   <= err_next_s;
    end
  end

  // RAM-side strobes/address/data; reset forces the IDLE values
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    if (RST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
    end else begin
      case (state_r)
        ST_IACC: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        ST_DACC: begin
          // a simultaneous read+write request is carried out as a write
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
        end
        default: begin
          ramREN = 1'b0;
          ramWEN = 1'b0;
        end
      endcase
    end
  end

  // Wait lines drop only in the completing cycle, never while in reset
  assign iwait = ~(i_done_s & ~RST);
  assign dwait = ~(d_done_s & ~RST);

  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_r;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of access cycles without ramready before an access is aborted (legal range 2..255).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 iREN  input  1  instruction-fetch request.
REQ-005 iaddr  input  32  instruction address.
REQ-006 iload  output  32  fetched instruction word.
REQ-007 iwait  output  1  low for exactly the cycle in which the fetch completes.
REQ-008 dREN  input  1  data read request.
REQ-009 dWEN  input  1  data write request.
REQ-010 daddr  input  32  data address.
REQ-011 dstore  input  32  data write word.
REQ-012 dload  output  32  data read word.
REQ-013 dwait  output  1  low for exactly the cycle in which the data access completes.
REQ-014 ramREN  output  1  RAM read strobe.
REQ-015 ramWEN  output  1  RAM write strobe.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramready  input  1  RAM access completes this cycle.
REQ-020 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states: IDLE, IACC (instruction access), DACC (data access); registered state.
REQ-022 IDLE: pending data (dREN|dWEN) -> DACC next cycle; else iREN -> IACC; else stay IDLE.
REQ-023 IDLE drives ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-024 IACC drives combinationally: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-025 DACC drives combinationally: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins when both set).
REQ-026 iload and dload equal ramload combinationally in all states.
REQ-027 Completion: in IACC with ramready=1, iwait=0 that cycle, next state IDLE; same for DACC/dwait.
REQ-028 Minimum latency: request seen in IDLE at cycle N, strobe at N+1, completion no earlier than N+1; one IDLE cycle separates consecutive accesses.
REQ-029 Requesters hold address/data/strobes stable while their wait is high; in IACC with iREN=0, or in DACC with dREN=dWEN=0, the access aborts to IDLE next cycle, no completion, no err.
REQ-030 8-bit counter cleared on entry to IACC/DACC, incremented each access cycle without ramready.
REQ-031 When counter reaches TIMEOUT-1 without ramready: err=1 for one cycle (the following cycle), state -> IDLE, wait stays high (no completion).
REQ-032 ramready in IDLE is ignored; ramready on the timeout cycle takes precedence (completion, no err).

Reset
REQ-033 RST=1 at a rising edge: state=IDLE, counter=0, err=0, last-grant=instruction; in-flight access dropped without completion.
REQ-034 While RST=1, outputs take the IDLE values of REQ-023; iload/dload follow ramload.

Configuration
REQ-035 Macro FAIR_ARB_EN: when defined, a last-grant flop records the requester of each access entered; in IDLE with both pending, grant goes to the requester not last granted (reset value instruction, so data wins first).
REQ-036 Without FAIR_ARB_EN: fixed priority, data always wins in IDLE; no last-grant flop.

Verification
REQ-037 Reset, then iREN=1 iaddr=0x100, ramready=1 from cycle 1 -> ramREN=1 ramaddr=0x100 at cycle 1, iwait=0 at cycle 1, iload=ramload.
REQ-038 dWEN=1 dREN=1 daddr=0x200 dstore=0xDEADBEEF -> ramWEN=1 ramREN=0 ramstore=0xDEADBEEF; dwait=0 on ramready.
REQ-039 iREN and dREN both held, ramready=1 -> fixed: data, data, ... starves instruction; FAIR_ARB_EN: grants alternate D, I, D, I.
REQ-040 TIMEOUT=4, dREN held, ramready=0 -> err=1 exactly one cycle after 4th access cycle, state IDLE, dwait never low; next access begins.
REQ-041 RST=1 asserted mid-DACC with ramready=1 the same cycle -> no dwait low after edge, ramREN=ramWEN=0, err=0.
